// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, encoded index and
// forced release after HOLD_MAX cycles of ownership.
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  rr_arbiter8_if.slave     bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StRel} state_e;

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [7:0] hold_q;
  logic [7:0] gnt_q;
  logic [2:0] idx_q;
  logic       valid_q;
  logic       timeout_q;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       owner_req;
  logic       hit_max;
  logic       release_now;

  // Scan from ptr upward with natural 3-bit wrap; first set bit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_req   = bus.req[idx_q];
    hit_max     = (hold_q == 8'(HOLD_MAX));
    release_now = bus.done || !owner_req || hit_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd0;
      hold_q    <= 8'd0;
      gnt_q     <= 8'd0;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q <= StGrant;
            gnt_q   <= 8'd1 << win_idx;
            idx_q   <= win_idx;
            valid_q <= 1'b1;
            hold_q  <= 8'd1;
          end
        end
        StGrant: begin
          if (release_now) begin
            state_q   <= StRel;
            gnt_q     <= 8'd0;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            ptr_q     <= idx_q + 3'd1;
            hold_q    <= 8'd0;
            // done and withdrawal both take precedence over a timeout report.
            timeout_q <= hit_max && !bus.done && owner_req;
          end else if (hold_q != 8'hFF) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        StRel:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, rotation, wrap, withdrawal, timeout and
// asynchronous reset during ownership.
module tb_rr_arbiter8;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rr_arbiter8_if bus();

  rr_arbiter8 #(.HOLD_MAX(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req  = 8'h00;
    bus.done = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic drain();
    bus.req  = 8'h00;
    bus.done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    #3;
    n_checks++;
    if ({bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%h idx=%0d v=%b to=%b, want all zero",
               bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout);
    end
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bus.req = 8'h04;
    tick();
    n_checks++;
    if (bus.gnt !== 8'h04 || bus.gnt_idx !== 3'd2 || bus.gnt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got gnt=%h idx=%0d v=%b, want 04 2 1",
               bus.gnt, bus.gnt_idx, bus.gnt_valid);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: got gnt=%h v=%b to=%b, want 00 0 0",
               bus.gnt, bus.gnt_valid, bus.timeout);
    end
    // ptr should now be 3: with 0 and 3 both requesting, 3 wins.
    bus.req = 8'h09;
    tick();
    tick();
    n_checks++;
    if (bus.gnt !== 8'h08 || bus.gnt_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL ptr_after_release: got gnt=%h idx=%0d, want 08 3", bus.gnt, bus.gnt_idx);
    end
    drain();
  endtask

  task automatic test_rotation();
    logic [2:0] exp_idx;
    do_reset();
    bus.req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      exp_idx = 3'(k);
      n_checks++;
      if (bus.gnt_idx !== exp_idx || bus.gnt !== (8'd1 << exp_idx) || bus.gnt_valid !== 1'b1)
      begin
        n_fail++;
        $display("FAIL rotation_%0d: got gnt=%h idx=%0d, want idx=%0d", k, bus.gnt,
                 bus.gnt_idx, exp_idx);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      n_checks++;
      if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rotation_gap_rel_%0d: got gnt=%h, want 00", k, bus.gnt);
      end
      tick();
      n_checks++;
      if (bus.gnt !== 8'h00) begin
        n_fail++;
        $display("FAIL rotation_gap_idle_%0d: got gnt=%h, want 00", k, bus.gnt);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_wrap();
    logic [2:0] exp_seq [3];
    exp_seq[0] = 3'd6;
    exp_seq[1] = 3'd0;
    exp_seq[2] = 3'd1;
    bus.req = 8'h20;
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 8'h43;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bus.gnt_idx !== exp_seq[k] || bus.gnt !== (8'd1 << exp_seq[k])) begin
        n_fail++;
        $display("FAIL wrap_%0d: got gnt=%h idx=%0d, want idx=%0d", k, bus.gnt,
                 bus.gnt_idx, exp_seq[k]);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      tick();
      tick();
    end
    drain();
  endtask

  task automatic test_withdraw();
    bus.req = 8'h02;
    tick();
    n_checks++;
    if (bus.gnt !== 8'h02) begin
      n_fail++;
      $display("FAIL withdraw_grant: got gnt=%h, want 02", bus.gnt);
    end
    bus.req = 8'h00;
    tick();
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_release: got gnt=%h to=%b, want 00 0", bus.gnt, bus.timeout);
    end
    drain();
  endtask

  task automatic test_timeout();
    int held;
    held = 0;
    bus.req = 8'h01;
    tick();
    for (int k = 0; k < 20; k++) begin
      if (bus.gnt === 8'h01 && bus.timeout === 1'b0) held++;
      else break;
      tick();
    end
    n_checks++;
    if (held !== 16) begin
      n_fail++;
      $display("FAIL timeout_hold_len: got %0d cycles, want 16", held);
    end
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_pulse: got gnt=%h to=%b, want 00 1", bus.gnt, bus.timeout);
    end
    tick();
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_dead: got gnt=%h to=%b, want 00 0", bus.gnt, bus.timeout);
    end
    tick();
    n_checks++;
    if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL timeout_regrant: got gnt=%h idx=%0d, want 01 0", bus.gnt, bus.gnt_idx);
    end
    drain();
  endtask

  task automatic test_done_at_max();
    bus.req = 8'h10;
    tick();
    repeat (15) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL done_at_max: got gnt=%h to=%b, want 00 0", bus.gnt, bus.timeout);
    end
    drain();
  endtask

  task automatic test_async_reset();
    bus.req = 8'h20;
    tick();
    n_checks++;
    if (bus.gnt !== 8'h20) begin
      n_fail++;
      $display("FAIL areset_setup: got gnt=%h, want 20", bus.gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_idx !== 3'd0 || bus.gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: got gnt=%h idx=%0d v=%b, want 00 0 0",
               bus.gnt, bus.gnt_idx, bus.gnt_valid);
    end
    #1;
    rst = 1'b0;
    bus.req = 8'h21;
    tick();
    n_checks++;
    if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0 || bus.gnt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_ptr0: got gnt=%h idx=%0d v=%b, want 01 0 1",
               bus.gnt, bus.gnt_idx, bus.gnt_valid);
    end
    drain();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_withdraw();
    test_timeout();
    test_done_at_max();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
